alu_result_fifo: RTL and testbench

- Downstream stage of the registered ALU. Captures each valid result/status pair the ALU produces and buffers it in a small first-word-fall-through FIFO.
- Drains entries to the consumer through a valid/ready handshake.
- Keeps saturating statistics on zero results and error results, plus a sticky flag for results dropped on overflow.
- The ALU has no backpressure, so this block is the only place results are held.

---
 rtl/alu_result_fifo.sv | 74 +++++++
 tb/tb_alu_result_fifo.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: FWFT buffer for registered ALU results with saturating zero/error statistics
// Ports:
//   i_clk, i_reset            clock, asynchronous active-high reset
//   i_valid/i_result/i_status ALU result stream (no backpressure)
//   i_clear                   synchronous flush of FIFO, counters and overflow flag
//   i_ready                   consumer ready
//   o_valid/o_data/o_data_status  head entry (reads 0 while empty)
//   o_count/o_full/o_empty    occupancy
//   o_overflow                sticky dropped-push flag
//   o_zero_count/o_err_count  saturating counts of accepted zero/error results
module alu_result_fifo #(
    parameter int K     = 8,
    parameter int DEPTH = 4,
    parameter int CW    = 8
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_valid,
    input  logic [K-1:0]               i_result,
    input  logic [3:0]                 i_status,
    input  logic                       i_clear,
    input  logic                       i_ready,
    output logic                       o_valid,
    output logic [K-1:0]               o_data,
    output logic [3:0]                 o_data_status,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty,
    output logic                       o_overflow,
    output logic [CW-1:0]              o_zero_count,
    output logic [CW-1:0]              o_err_count
);
    localparam int AW = $clog2(DEPTH);
    logic [K-1:0]  mem_data   [DEPTH];
    logic [3:0]    mem_status [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count_n;
    logic          pop, push;
    assign pop     = !o_empty && i_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign push    = i_valid && (!o_full || pop);
    assign count_n = o_count + (AW+1)'(push) - (AW+1)'(pop);
    assign o_valid       = !o_empty;
    assign o_data        = o_empty ? '0 : mem_data[rd_ptr];
    assign o_data_status = o_empty ? '0 : mem_status[rd_ptr];
    always_ff @(posedge i_clk) begin
        if (push && !i_clear) begin
            mem_data[wr_ptr]   <= i_result;
            mem_status[wr_ptr] <= i_status;
        end
    end
    // Full/empty are registered alongside the count so every status output is a flop
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset || i_clear) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            o_count      <= '0;
            o_full       <= 1'b0;
            o_empty      <= 1'b1;
            o_overflow   <= 1'b0;
            o_zero_count <= '0;
            o_err_count  <= '0;
        end else begin
            rd_ptr       <= rd_ptr + AW'(pop);
            wr_ptr       <= wr_ptr + AW'(push);
            o_count      <= count_n;
            o_full       <= count_n == (AW+1)'(DEPTH);
            o_empty      <= count_n == '0;
            o_overflow   <= o_overflow || (i_valid && !push);
            o_zero_count <= o_zero_count + CW'(push && i_status[1] && o_zero_count != '1);
            o_err_count  <= o_err_count + CW'(push && i_status[0] && o_err_count != '1);
        end
    end
endmodule

// File: tb/tb_alu_result_fifo.sv
// tb_alu_result_fifo: directed self-checking bench for alu_result_fifo
module tb_alu_result_fifo;
    logic       clk = 0, rst = 1;
    logic       i_valid = 0, i_clear = 0, i_ready = 0;
    logic [7:0] i_result = 0;
    logic [3:0] i_status = 0;
    logic       o_valid, o_full, o_empty, o_overflow;
    logic [7:0] o_data, o_zero_count, o_err_count;
    logic [3:0] o_data_status;
    logic [2:0] o_count;
    int checks = 0, failures = 0;

    alu_result_fifo #(.K(8), .DEPTH(4), .CW(8)) dut (
        .i_clk(clk), .i_reset(rst), .i_valid(i_valid), .i_result(i_result),
        .i_status(i_status), .i_clear(i_clear), .i_ready(i_ready),
        .o_valid(o_valid), .o_data(o_data), .o_data_status(o_data_status),
        .o_count(o_count), .o_full(o_full), .o_empty(o_empty),
        .o_overflow(o_overflow), .o_zero_count(o_zero_count), .o_err_count(o_err_count)
    );

    always #5 clk = ~clk;

    task automatic test_reset;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        checks++; if (o_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", o_empty); end
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
        checks++; if (o_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", o_full); end
        checks++; if (o_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", o_count); end
        checks++; if (o_data !== 8'h00 || o_data_status !== 4'h0) begin failures++; $display("FAIL reset_data got=%h/%h exp=00/0", o_data, o_data_status); end
        checks++; if (o_overflow !== 1'b0 || o_zero_count !== 8'd0 || o_err_count !== 8'd0) begin failures++; $display("FAIL reset_stats got=%b/%0d/%0d exp=0/0/0", o_overflow, o_zero_count, o_err_count); end
    endtask

    task automatic test_single;
        i_valid = 1; i_result = 8'h5A; i_status = 4'h4; i_ready = 0;
        @(negedge clk);
        i_valid = 0;
        checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", o_valid); end
        checks++; if (o_data !== 8'h5A || o_data_status !== 4'h4) begin failures++; $display("FAIL single_data got=%h/%h exp=5a/4", o_data, o_data_status); end
        checks++; if (o_count !== 3'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", o_count); end
        @(negedge clk);
        checks++; if (o_data !== 8'h5A || o_valid !== 1'b1) begin failures++; $display("FAIL single_hold got=%h/%b exp=5a/1", o_data, o_valid); end
        i_ready = 1;
        @(negedge clk);
        i_ready = 0;
        checks++; if (o_empty !== 1'b1 || o_valid !== 1'b0 || o_data !== 8'h00) begin failures++; $display("FAIL single_drain got=%b/%b/%h exp=1/0/00", o_empty, o_valid, o_data); end
        checks++; if (o_zero_count !== 8'd0 || o_err_count !== 8'd0) begin failures++; $display("FAIL single_stats got=%0d/%0d exp=0/0", o_zero_count, o_err_count); end
    endtask

    task automatic test_overflow;
        i_status = 4'h0; i_ready = 0;
        for (int i = 1; i <= 4; i++) begin
            i_valid = 1; i_result = 8'(i);
            @(negedge clk);
        end
        i_valid = 0;
        checks++; if (o_full !== 1'b1 || o_count !== 3'd4 || o_overflow !== 1'b0) begin failures++; $display("FAIL ovf_full got=%b/%0d/%b exp=1/4/0", o_full, o_count, o_overflow); end
        i_valid = 1; i_result = 8'h05;
        @(negedge clk);
        i_valid = 0;
        checks++; if (o_overflow !== 1'b1 || o_count !== 3'd4) begin failures++; $display("FAIL ovf_drop got=%b/%0d exp=1/4", o_overflow, o_count); end
        i_ready = 1;
        for (int i = 1; i <= 4; i++) begin
            checks++; if (o_data !== 8'(i) || o_valid !== 1'b1) begin failures++; $display("FAIL ovf_order got=%h/%b exp=%h/1", o_data, o_valid, 8'(i)); end
            @(negedge clk);
        end
        i_ready = 0;
        checks++; if (o_empty !== 1'b1 || o_overflow !== 1'b1) begin failures++; $display("FAIL ovf_after got=%b/%b exp=1/1", o_empty, o_overflow); end
        i_clear = 1;
        @(negedge clk);
        i_clear = 0;
        checks++; if (o_overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", o_overflow); end
    endtask

    task automatic test_full_push_pop;
        logic [7:0] exp_q [4] = '{8'h12, 8'h13, 8'h14, 8'h77};
        i_status = 4'h0; i_ready = 0;
        for (int i = 0; i < 4; i++) begin
            i_valid = 1; i_result = 8'h11 + 8'(i);
            @(negedge clk);
        end
        i_valid = 1; i_result = 8'h77; i_ready = 1;
        @(negedge clk);
        i_valid = 0;
        checks++; if (o_count !== 3'd4 || o_full !== 1'b1 || o_overflow !== 1'b0) begin failures++; $display("FAIL fpp_count got=%0d/%b/%b exp=4/1/0", o_count, o_full, o_overflow); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (o_data !== exp_q[i]) begin failures++; $display("FAIL fpp_order got=%h exp=%h", o_data, exp_q[i]); end
            @(negedge clk);
        end
        i_ready = 0;
        checks++; if (o_empty !== 1'b1 || o_err_count !== 8'd0 || o_zero_count !== 8'd0) begin failures++; $display("FAIL fpp_end got=%b/%0d/%0d exp=1/0/0", o_empty, o_err_count, o_zero_count); end
    endtask

    task automatic test_saturate;
        i_ready = 1; i_valid = 1; i_status = 4'h3;
        for (int i = 0; i < 254; i++) begin
            i_result = 8'(i);
            @(negedge clk);
        end
        checks++; if (o_zero_count !== 8'd254 || o_err_count !== 8'd254) begin failures++; $display("FAIL sat_mid got=%0d/%0d exp=254/254", o_zero_count, o_err_count); end
        checks++; if (o_count !== 3'd1 || o_data !== 8'd253) begin failures++; $display("FAIL sat_stream got=%0d/%h exp=1/fd", o_count, o_data); end
        for (int i = 254; i < 300; i++) begin
            i_result = 8'(i);
            @(negedge clk);
        end
        i_valid = 0;
        @(negedge clk);
        i_ready = 0;
        checks++; if (o_zero_count !== 8'd255 || o_err_count !== 8'd255) begin failures++; $display("FAIL sat_final got=%0d/%0d exp=255/255", o_zero_count, o_err_count); end
        checks++; if (o_overflow !== 1'b0 || o_empty !== 1'b1) begin failures++; $display("FAIL sat_flags got=%b/%b exp=0/1", o_overflow, o_empty); end
    endtask

    task automatic test_clear;
        i_clear = 1;
        @(negedge clk);
        i_clear = 0;
        checks++; if (o_zero_count !== 8'd0 || o_err_count !== 8'd0) begin failures++; $display("FAIL clr_stats0 got=%0d/%0d exp=0/0", o_zero_count, o_err_count); end
        i_status = 4'h1; i_ready = 0;
        for (int i = 0; i < 5; i++) begin
            i_valid = 1; i_result = 8'h21 + 8'(i);
            @(negedge clk);
        end
        i_valid = 0;
        checks++; if (o_err_count !== 8'd4 || o_overflow !== 1'b1 || o_zero_count !== 8'd0) begin failures++; $display("FAIL clr_dropcnt got=%0d/%b/%0d exp=4/1/0", o_err_count, o_overflow, o_zero_count); end
        i_ready = 1;
        @(negedge clk);
        i_ready = 0;
        checks++; if (o_count !== 3'd3 || o_data !== 8'h22) begin failures++; $display("FAIL clr_three got=%0d/%h exp=3/22", o_count, o_data); end
        i_clear = 1; i_valid = 1; i_result = 8'h99; i_status = 4'h3;
        @(negedge clk);
        i_clear = 0; i_valid = 0;
        checks++; if (o_count !== 3'd0 || o_empty !== 1'b1 || o_overflow !== 1'b0) begin failures++; $display("FAIL clr_fifo got=%0d/%b/%b exp=0/1/0", o_count, o_empty, o_overflow); end
        checks++; if (o_zero_count !== 8'd0 || o_err_count !== 8'd0) begin failures++; $display("FAIL clr_stats got=%0d/%0d exp=0/0", o_zero_count, o_err_count); end
        @(negedge clk);
        checks++; if (o_valid !== 1'b0 || o_data !== 8'h00) begin failures++; $display("FAIL clr_nopush got=%b/%h exp=0/00", o_valid, o_data); end
    endtask

    task automatic test_async_reset;
        i_status = 4'h3; i_ready = 0;
        for (int i = 0; i < 3; i++) begin
            i_valid = 1; i_result = 8'h41 + 8'(i);
            @(negedge clk);
        end
        i_valid = 0; i_ready = 1;
        @(negedge clk);
        checks++; if (o_count !== 3'd2 || o_data !== 8'h42) begin failures++; $display("FAIL ar_pre got=%0d/%h exp=2/42", o_count, o_data); end
        #2 rst = 1;
        #1;
        checks++; if (o_count !== 3'd0 || o_empty !== 1'b1 || o_valid !== 1'b0 || o_full !== 1'b0) begin failures++; $display("FAIL ar_occ got=%0d/%b/%b/%b exp=0/1/0/0", o_count, o_empty, o_valid, o_full); end
        checks++; if (o_data !== 8'h00 || o_data_status !== 4'h0) begin failures++; $display("FAIL ar_data got=%h/%h exp=00/0", o_data, o_data_status); end
        checks++; if (o_zero_count !== 8'd0 || o_err_count !== 8'd0 || o_overflow !== 1'b0) begin failures++; $display("FAIL ar_stats got=%0d/%0d/%b exp=0/0/0", o_zero_count, o_err_count, o_overflow); end
        i_ready = 0;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        checks++; if (o_empty !== 1'b1 || o_count !== 3'd0) begin failures++; $display("FAIL ar_after got=%b/%0d exp=1/0", o_empty, o_count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_full_push_pop();
        test_saturate();
        test_clear();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
